// File: rtl/traffic_phase_arbiter_if.sv
// rtl/traffic_phase_arbiter_if.sv - signal bundle between the phase arbiter and its environment
//
// Purpose: groups the timing enable, demand/preemption inputs and the light,
// grant and pending outputs of traffic_phase_arbiter.
//   master : environment side (drives tick/req/preempt/preempt_dir)
//   slave  : arbiter side (drives lights, grant, pending)
// Lights are {red,yellow,green}: 100 red, 010 yellow, 001 green.
interface traffic_phase_arbiter_if;
    logic       tick;
    logic [3:0] req;
    logic       preempt;
    logic [1:0] preempt_dir;
    logic [2:0] Main_North_Lights;
    logic [2:0] Main_South_Lights;
    logic [2:0] Local_East_Lights;
    logic [2:0] Local_West_Lights;
    logic [3:0] grant;
    logic [3:0] pending;

    modport master (
        output tick, req, preempt, preempt_dir,
        input  Main_North_Lights, Main_South_Lights, Local_East_Lights, Local_West_Lights,
        input  grant, pending
    );

    modport slave (
        input  tick, req, preempt, preempt_dir,
        output Main_North_Lights, Main_South_Lights, Local_East_Lights, Local_West_Lights,
        output grant, pending
    );
endinterface

// File: rtl/traffic_phase_arbiter.sv
// rtl/traffic_phase_arbiter.sv - four-approach traffic phase arbiter with preemption
//
// Purpose: serves one approach at a time through GREEN -> YELLOW -> CLEAR,
// picking the next approach round-robin from latched demand, with an
// emergency preemption override. Timers advance only on tick.
// Ports:
//   clk            single clock, rising edge
//   rst_a          synchronous active-low reset
//   bus.tick       timing enable
//   bus.req[3:0]   demand, bit0=N bit1=S bit2=E bit3=W
//   bus.preempt    level-sensitive emergency request
//   bus.preempt_dir approach given priority while preempt=1
//   bus.*_Lights   {red,yellow,green} per approach
//   bus.grant      one-hot approach in GREEN or YELLOW, else 0
//   bus.pending    latched unserved demand
module traffic_phase_arbiter #(
    parameter int MIN_GREEN   = 4,
    parameter int MAX_GREEN   = 8,
    parameter int YELLOW_TIME = 2,
    parameter int ALLRED_TIME = 1
) (
    input  logic                    clk,
    input  logic                    rst_a,
    traffic_phase_arbiter_if.slave  bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GREEN  = 2'd1;
    localparam logic [1:0] ST_YELLOW = 2'd2;
    localparam logic [1:0] ST_CLEAR  = 2'd3;

    localparam logic [3:0] MIN_LAST    = 4'(MIN_GREEN - 1);
    localparam logic [3:0] MAX_LAST    = 4'(MAX_GREEN - 1);
    localparam logic [3:0] YELLOW_LAST = 4'(YELLOW_TIME - 1);
    localparam logic [3:0] CLEAR_LAST  = 4'(ALLRED_TIME - 1);

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    logic [1:0] state, state_nx;
    logic [3:0] timer, timer_nx;
    logic [1:0] served, served_nx;
    logic [3:0] pending, pending_nx;

    logic [3:0] demand;
    logic [3:0] served_oh;
    logic [3:0] conflict;
    logic [1:0] winner;
    logic       winner_found;
    logic [1:0] pick;
    logic       pick_valid;
    logic       enter_green;
    logic       green_exit;

    assign demand    = pending | bus.req;
    assign served_oh = 4'b0001 << served;
    assign conflict  = demand & ~served_oh;

    // Round-robin scan starting just after the last served approach.
    always_comb begin
        logic [1:0] idx;
        winner       = served + 2'd1;
        winner_found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = served + 2'(k + 1);
            if (!winner_found && demand[idx]) begin
                winner       = idx;
                winner_found = 1'b1;
            end
        end
    end

    // Next approach to turn green when leaving CLEAR or IDLE.
    always_comb begin
        pick       = winner;
        pick_valid = 1'b0;
        if (bus.preempt) begin
            pick       = bus.preempt_dir;
            pick_valid = 1'b1;
        end else if (winner_found) begin
            pick_valid = 1'b1;
        end
    end

    // Preemption for another approach ends green immediately; preemption for
    // the served approach holds green; otherwise the min/max rule applies.
    always_comb begin
        green_exit = 1'b0;
        if (bus.preempt) begin
            green_exit = (served != bus.preempt_dir);
        end else begin
            green_exit = (timer >= MIN_LAST) && (|conflict) &&
                         (!bus.req[served] || (timer >= MAX_LAST));
        end
    end

    always_comb begin
        state_nx    = state;
        timer_nx    = timer;
        served_nx   = served;
        enter_green = 1'b0;
        if (bus.tick) begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state_nx    = ST_GREEN;
                        served_nx   = pick;
                        timer_nx    = 4'd0;
                        enter_green = 1'b1;
                    end
                end
                ST_GREEN: begin
                    if (green_exit) begin
                        state_nx = ST_YELLOW;
                        timer_nx = 4'd0;
                    end else if (timer != 4'd15) begin
                        timer_nx = timer + 4'd1;
                    end
                end
                ST_YELLOW: begin
                    if (timer == YELLOW_LAST) begin
                        state_nx = ST_CLEAR;
                        timer_nx = 4'd0;
                    end else begin
                        timer_nx = timer + 4'd1;
                    end
                end
                default: begin
                    if (timer == CLEAR_LAST) begin
                        timer_nx = 4'd0;
                        if (pick_valid) begin
                            state_nx    = ST_GREEN;
                            served_nx   = pick;
                            enter_green = 1'b1;
                        end else begin
                            state_nx = ST_IDLE;
                        end
                    end else begin
                        timer_nx = timer + 4'd1;
                    end
                end
            endcase
        end
    end

    // Demand latches every cycle; the approach turning green loses its bit
    // even if it is still requesting on that same cycle.
    always_comb begin
        pending_nx = pending | bus.req;
        if (enter_green) begin
            pending_nx[served_nx] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_a) begin
            state   <= ST_CLEAR;
            timer   <= 4'd0;
            served  <= 2'd3;
            pending <= 4'd0;
        end else begin
            state   <= state_nx;
            timer   <= timer_nx;
            served  <= served_nx;
            pending <= pending_nx;
        end
    end

    logic [3:0] grant_w;
    logic [2:0] lamp_on;

    assign grant_w = ((state == ST_GREEN) || (state == ST_YELLOW)) ? served_oh : 4'd0;
    assign lamp_on = (state == ST_GREEN) ? LAMP_GREEN : LAMP_YELLOW;

    assign bus.grant             = grant_w;
    assign bus.pending           = pending;
    assign bus.Main_North_Lights = grant_w[0] ? lamp_on : LAMP_RED;
    assign bus.Main_South_Lights = grant_w[1] ? lamp_on : LAMP_RED;
    assign bus.Local_East_Lights = grant_w[2] ? lamp_on : LAMP_RED;
    assign bus.Local_West_Lights = grant_w[3] ? lamp_on : LAMP_RED;

endmodule
